regs_dump: RTL
==============

# regs_dump

Sequential read-out engine for the picoMIPS 2^R_SIZE × n register file (register %0 hard-wired to 0). On a start pulse it drives the register file's read address through every register from %0 to the top, captures each value and presents it on a valid/ready output port, accumulating a modulo-2^n checksum. It sits beside `regs` on one read port and feeds a debug sink (LED/UART/display) or a bench checker. It is the reading end of the register file interface.

## Interface
- n, 8, data width of each register
- R_SIZE, 2, register address width; register count = 2^R_SIZE
- clk  input  1  system clock; all state updates on rising edge
- nReset  input  1  synchronous, active-low reset
- start  input  1  request a dump; sampled only in IDLE
- Raddr  output  R_SIZE  read address to the `regs` read port
- Rdata  input  n  read data from `regs`; combinational (asynchronous) read of Raddr
- dout  output  n  captured register value
- dout_addr  output  R_SIZE  register number of dout
- dout_valid  output  1  dout/dout_addr valid
- dout_ready  input  1  sink accepts the current word
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse after the last word is accepted
- checksum  output  n  sum of accepted words, modulo 2^n
- zero_err  output  1  sticky: %0 read back non-zero during the current/last dump

## Operation
- States: IDLE, FETCH, PRESENT, DONE; 2-bit state register.
- IDLE: Raddr=0, busy=0, dout_valid=0. start=1 → FETCH; address counter ← 0, checksum ← 0, zero_err ← 0.
- FETCH: Raddr = counter; at clock edge dout ← Rdata, dout_addr ← counter; if counter==0 and Rdata≠0, zero_err ← 1; → PRESENT.
- PRESENT: dout_valid=1; dout, dout_addr, Raddr held stable until the handshake (dout_valid & dout_ready at an edge). On handshake: checksum ← checksum + dout (carry discarded); if counter == 2^R_SIZE−1 → DONE, else counter+1 → FETCH.
- DONE: done=1 for exactly this cycle, dout_valid=0; → IDLE unconditionally.
- start while busy is ignored (no restart, no queueing). start held high through DONE begins a new dump on the first IDLE cycle (checksum and zero_err cleared then).
- checksum and zero_err keep their final values in IDLE until the next accepted start.
- Counter never wraps inside a dump; termination is by the last-address compare.
- dout_ready while dout_valid=0 has no effect.

## Timing
- Reset (nReset=0 at an edge, any state, including mid-dump): state=IDLE, counter=0, Raddr=0, dout=0, dout_addr=0, dout_valid=0, busy=0, done=0, checksum=0, zero_err=0. A handshake in the same cycle as reset is discarded.
- start sampled at edge k → FETCH during cycle k+1, dout_valid high from cycle k+2.
- Per word: 1 FETCH cycle + ≥1 PRESENT cycle; with dout_ready tied high, 2 cycles per register, 2·2^R_SIZE cycles from the first FETCH to DONE.
- R_SIZE=2, ready high: start at edge 0 → words valid in cycles 2,4,6,8; done in cycle 9; busy low from cycle 10.
- Rdata must be settled within the FETCH cycle; no register-file write to the addressed register is expected during FETCH (a write lands in the next dump only).

## Test plan
- Registers {%0..%3}={0,7,6,5}, ready tied high, start pulse → words (0,0),(1,7),(2,6),(3,5) in cycles 2,4,6,8; done in cycle 9; checksum=18; zero_err=0.
- Same contents, dout_ready low for 3 cycles on word %2 → dout=6, dout_addr=2 held stable all 3 cycles; word counted once; checksum=18.
- Registers {0,0xFF,0x02,0x01} → checksum=0x02 (mod 256 wrap); done pulse exactly one cycle.
- Fault model drives %0=0x04 → zero_err=1 after word 0, sticky through DONE/IDLE; cleared by next start.
- nReset low during PRESENT of word %1 → next edge all outputs zero, state IDLE; new start gives a full dump from %0.
- start pulsed again while busy → ignored, exactly 4 words and one done; start held high → second dump begins in the cycle after done.

Source files
------------

// File: rtl/regs_dump.sv
// Sequential read-out engine for the register file: walks every register
// from %0 upwards, presents each word on a valid/ready port and sums them.
module regs_dump #(
    parameter int n      = 8,
    parameter int R_SIZE = 2
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              start,
    output logic [R_SIZE-1:0] Raddr,
    input  logic [n-1:0]      Rdata,
    output logic [n-1:0]      dout,
    output logic [R_SIZE-1:0] dout_addr,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              done,
    output logic [n-1:0]      checksum,
    output logic              zero_err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FETCH   = 2'd1;
    localparam logic [1:0] S_PRESENT = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [R_SIZE-1:0] LAST_ADDR = '1;
    localparam logic [R_SIZE-1:0] ONE       = R_SIZE'(1);

    logic [1:0]        state_q, state_d;
    logic [R_SIZE-1:0] cnt_q, cnt_d;
    logic [n-1:0]      dout_q, dout_d;
    logic [R_SIZE-1:0] addr_q, addr_d;
    logic [n-1:0]      sum_q, sum_d;
    logic              zerr_q, zerr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        addr_d  = addr_q;
        sum_d   = sum_q;
        zerr_d  = zerr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                    sum_d   = '0;
                    zerr_d  = 1'b0;
                end
            end
            S_FETCH: begin
                dout_d  = Rdata;
                addr_d  = cnt_q;
                if (cnt_q == '0 && Rdata != '0) begin
                    zerr_d = 1'b1;
                end
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                if (dout_ready) begin
                    sum_d = sum_q + dout_q;
                    // Termination is by last-address compare; the counter never wraps.
                    if (cnt_q == LAST_ADDR) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + ONE;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dout_q  <= '0;
            addr_q  <= '0;
            sum_q   <= '0;
            zerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            addr_q  <= addr_d;
            sum_q   <= sum_d;
            zerr_q  <= zerr_d;
        end
    end

    assign Raddr      = (state_q == S_FETCH || state_q == S_PRESENT) ? cnt_q : '0;
    assign dout       = dout_q;
    assign dout_addr  = addr_q;
    assign dout_valid = (state_q == S_PRESENT);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign checksum   = sum_q;
    assign zero_err   = zerr_q;

endmodule
